// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared types for the CPU clock sequencer: FSM state encoding and mode switch codes.
// Imported by cpu_clk_ctrl; the mode-to-state mapping lives here so both stay in sync.
package cpu_clk_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN_FAST = 2'd0,
    RUN_SLOW = 2'd1,
    STEP     = 2'd2,
    HALT     = 2'd3
  } state_t;

  localparam logic [1:0] MODE_FAST = 2'b00;
  localparam logic [1:0] MODE_SLOW = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;
  localparam logic [1:0] MODE_HALT = 2'b11;

  function automatic state_t mode_to_state(input logic [1:0] m);
    state_t s;
    case (m)
      MODE_FAST: s = RUN_FAST;
      MODE_SLOW: s = RUN_SLOW;
      MODE_STEP: s = STEP;
      default:   s = HALT;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, and a registered
// one-clk pulse on each accepted press (release is debounced too but never pulses).
module btn_debounce #(
  parameter int DEB_W = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam logic [DEB_W-1:0] CNT_LAST = {DEB_W{1'b1}} - DEB_W'(1);

  logic             btn_m;
  logic             btn_s;
  logic             btn_db;
  logic [DEB_W-1:0] cnt;
  logic             differ;
  logic             accept;

  assign differ = (btn_s != btn_db);
  // The synchronised level has now disagreed with the accepted level for 2^DEB_W-1 clks.
  assign accept = differ && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_m  <= 1'b0;
      btn_s  <= 1'b0;
      btn_db <= 1'b0;
      cnt    <= '0;
      pulse  <= 1'b0;
    end else begin
      btn_m <= btn;
      btn_s <= btn_m;
      pulse <= accept & btn_s;
      if (!differ) begin
        cnt <= '0;
      end else if (accept) begin
        cnt    <= '0;
        btn_db <= btn_s;
      end else begin
        cnt <= cnt + DEB_W'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock sequencer: turns a divider tap, a debounced step button or nothing (halt)
// into a one-clk cpu_ce pulse. Define CPU_CYCLE_CNT_EN to build the cycle_cnt counter.
module cpu_clk_ctrl
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int DIV_W    = 32,
  parameter int FAST_TAP = 1,
  parameter int SLOW_TAP = 24,
  parameter int DEB_W    = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] clkdiv,
  input  logic [1:0]       mode,
  input  logic             step_btn,
  input  logic             halt_req,
  input  logic             resume,
  output logic             cpu_ce,
  output logic             cpu_clk,
  output logic [1:0]       state,
  output logic [31:0]      cycle_cnt
);

  logic [1:0] mode_m;
  logic [1:0] mode_s;
  logic       step_p;
  state_t     state_q;
  state_t     state_d;
  logic       ce_d;
  logic       tap_cur;
  logic       tap_nxt;
  logic       tap_q;
  logic       tick;
  logic       unused_div;

  // Only two taps of the divider are used; fold the rest away.
  assign unused_div = ^clkdiv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_m <= MODE_FAST;
      mode_s <= MODE_FAST;
    end else begin
      mode_m <= mode;
      mode_s <= mode_m;
    end
  end

  btn_debounce #(
    .DEB_W(DEB_W)
  ) u_step_deb (
    .clk  (clk),
    .rst  (rst),
    .btn  (step_btn),
    .pulse(step_p)
  );

  // tap_q always holds the tap of the state being entered, so a mode switch reloads the
  // edge detector and the first pulse afterwards needs a genuine 0->1 of the new tap.
  assign tap_cur = (state_q == RUN_SLOW) ? clkdiv[SLOW_TAP] : clkdiv[FAST_TAP];
  assign tap_nxt = (state_d == RUN_SLOW) ? clkdiv[SLOW_TAP] : clkdiv[FAST_TAP];
  assign tick    = tap_cur & ~tap_q;

  always_comb begin
    state_d = state_q;
    ce_d    = 1'b0;
    case (state_q)
      RUN_FAST, RUN_SLOW, STEP: begin
        ce_d = (state_q == STEP) ? step_p : tick;
        if (halt_req) begin
          state_d = HALT;
          ce_d    = 1'b0;
        end else begin
          state_d = mode_to_state(mode_s);
        end
      end
      HALT: begin
        ce_d = (mode_s == MODE_STEP) & step_p;
        if (resume && !halt_req && (mode_s != MODE_HALT)) begin
          state_d = mode_to_state(mode_s);
        end
      end
      default: state_d = HALT;
    endcase
    // Guarantees a gap after every pulse, even across a tap switch.
    if (cpu_ce) begin
      ce_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HALT;
      tap_q   <= 1'b0;
      cpu_ce  <= 1'b0;
      cpu_clk <= 1'b0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_nxt;
      cpu_ce  <= ce_d;
      cpu_clk <= cpu_clk ^ ce_d;
    end
  end

  assign state = state_q;

`ifdef CPU_CYCLE_CNT_EN
  logic [31:0] cnt_r;

  // Counts with ce_d so cycle_cnt already includes a pulse while cpu_ce is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= 32'd0;
    end else if (ce_d) begin
      cnt_r <= cnt_r + 32'd1;
    end
  end

  assign cycle_cnt = cnt_r;
`else
  assign cycle_cnt = 32'd0;
`endif

endmodule
